// File: rtl/apb_timer_completer_if.sv
// rtl/apb_timer_completer_if.sv - APB bus bundle between the master and the timer completer
interface apb_timer_completer_if;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PADDR;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PSEL, PENABLE, PADDR, PWRITE, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PADDR, PWRITE, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_timer_completer.sv
// rtl/apb_timer_completer.sv - APB completer with 32-bit down-counting timer, prescaler, reload and irq
// Optional error responses: define APB_TIMER_PSLVERR_EN to drive PSLVERR on bad decode / COUNT writes.
module apb_timer_completer #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  apb_timer_completer_if.slave bus,
  output logic                 irq
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY} state_t;

  // Wait counter preset; meaningless when no wait states are configured.
  localparam logic [3:0] LP_WCNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  localparam logic [1:0] LP_REG_CTRL   = 2'd0;
  localparam logic [1:0] LP_REG_LOAD   = 2'd1;
  localparam logic [1:0] LP_REG_COUNT  = 2'd2;
  localparam logic [1:0] LP_REG_STATUS = 2'd3;

  state_t      r_state;
  logic [3:0]  r_wcnt;
  logic [31:0] r_prdata;
  logic        r_pready;

  logic        r_en;
  logic        r_auto;
  logic        r_irq_en;
  logic [7:0]  r_presc_val;
  logic [31:0] r_load;
  logic [31:0] r_count;
  logic        r_expired;
  logic [7:0]  r_presc;

  logic        w_hit;
  logic [1:0]  w_reg;
  logic        w_setup;
  logic        w_enter_ready;
  logic        w_commit;
  logic        w_tick;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_hit    = (bus.PADDR[31:4] == BASE_ADDR[31:4]);
  assign w_reg    = bus.PADDR[3:2];
  assign w_setup  = bus.PSEL & ~bus.PENABLE;
  assign w_unused = &{1'b0, bus.PADDR[1:0]};

  // Decide when the bus FSM moves into its single completing cycle.
  always_comb begin
    w_enter_ready = 1'b0;
    if (r_state == S_IDLE && w_setup && WAIT_STATES == 0)
      w_enter_ready = 1'b1;
    else if (r_state == S_WAIT && bus.PSEL && r_wcnt == 4'd0)
      w_enter_ready = 1'b1;
  end

  // Writes take effect only at the end of the completing cycle, and only when decoded.
  assign w_commit = (r_state == S_READY) & bus.PWRITE & w_hit;
  assign w_tick   = r_en & (r_presc == r_presc_val);

  // Read mux; undecoded addresses read as zero.
  always_comb begin
    w_rdata = 32'd0;
    if (w_hit) begin
      case (w_reg)
        LP_REG_CTRL:   w_rdata = {16'd0, r_presc_val, 5'd0, r_irq_en, r_auto, r_en};
        LP_REG_LOAD:   w_rdata = r_load;
        LP_REG_COUNT:  w_rdata = r_count;
        LP_REG_STATUS: w_rdata = {31'd0, r_expired};
        default:       w_rdata = 32'd0;
      endcase
    end
  end

  // Bus FSM with registered PREADY/PRDATA; an early PSEL drop in WAIT aborts the transfer.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state  <= S_IDLE;
      r_wcnt   <= 4'd0;
      r_prdata <= 32'd0;
      r_pready <= 1'b0;
    end else begin
      r_pready <= w_enter_ready;
      if (w_enter_ready && !bus.PWRITE)
        r_prdata <= w_rdata;
      case (r_state)
        S_IDLE: begin
          if (w_setup) begin
            if (WAIT_STATES == 0) begin
              r_state <= S_READY;
            end else begin
              r_state <= S_WAIT;
              r_wcnt  <= LP_WCNT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (!bus.PSEL)
            r_state <= S_IDLE;
          else if (r_wcnt == 4'd0)
            r_state <= S_READY;
          else
            r_wcnt <= r_wcnt - 4'd1;
        end
        S_READY: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Timer: prescaled ticks decrement COUNT; a LOAD write beats a tick, an expire beats a W1C.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_en        <= 1'b0;
      r_auto      <= 1'b0;
      r_irq_en    <= 1'b0;
      r_presc_val <= 8'd0;
      r_load      <= 32'd0;
      r_count     <= 32'd0;
      r_expired   <= 1'b0;
      r_presc     <= 8'd0;
    end else begin
      if (!r_en || w_tick)
        r_presc <= 8'd0;
      else
        r_presc <= r_presc + 8'd1;

      if (w_commit && w_reg == LP_REG_CTRL) begin
        r_en        <= bus.PWDATA[0];
        r_auto      <= bus.PWDATA[1];
        r_irq_en    <= bus.PWDATA[2];
        r_presc_val <= bus.PWDATA[15:8];
      end

      if (w_commit && w_reg == LP_REG_LOAD) begin
        r_load  <= bus.PWDATA;
        r_count <= bus.PWDATA;
      end else if (w_tick) begin
        if (r_count == 32'd0)
          r_count <= r_auto ? r_load : 32'd0;
        else
          r_count <= r_count - 32'd1;
      end

      if (w_tick && r_count == 32'd0)
        r_expired <= 1'b1;
      else if (w_commit && w_reg == LP_REG_STATUS && bus.PWDATA[0])
        r_expired <= 1'b0;
    end
  end

`ifdef APB_TIMER_PSLVERR_EN
  logic r_pslverr;
  logic w_err;

  assign w_err = ~w_hit | (bus.PWRITE & (w_reg == LP_REG_COUNT));

  // Error flag is captured with the completing cycle, same as PREADY.
  always_ff @(posedge PCLK) begin
    if (PRESET)
      r_pslverr <= 1'b0;
    else
      r_pslverr <= w_enter_ready & w_err;
  end

  assign bus.PSLVERR = r_pslverr;
`else
  assign bus.PSLVERR = 1'b0;
`endif

  assign bus.PRDATA = r_prdata;
  assign bus.PREADY = r_pready;
  assign irq        = r_expired & r_irq_en;

endmodule

// File: tb/tb_apb_timer_completer.sv
// tb/tb_apb_timer_completer.sv - self-checking bench for apb_timer_completer (0 and 2 wait states)
module tb_apb_timer_completer;

  localparam logic [31:0] A_CTRL   = 32'h0000_1000;
  localparam logic [31:0] A_LOAD   = 32'h0000_1004;
  localparam logic [31:0] A_COUNT  = 32'h0000_1008;
  localparam logic [31:0] A_STATUS = 32'h0000_100C;

`ifdef APB_TIMER_PSLVERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        m_sel   = 1'b0;
  logic        m_psel  = 1'b0;
  logic        m_pen   = 1'b0;
  logic [31:0] m_addr  = 32'd0;
  logic        m_wr    = 1'b0;
  logic [31:0] m_wdata = 32'd0;

  apb_timer_completer_if if0 ();
  apb_timer_completer_if if2 ();
  logic irq0, irq2;

  assign if0.PSEL    = m_psel & ~m_sel;
  assign if0.PENABLE = m_pen;
  assign if0.PADDR   = m_addr;
  assign if0.PWRITE  = m_wr;
  assign if0.PWDATA  = m_wdata;
  assign if2.PSEL    = m_psel & m_sel;
  assign if2.PENABLE = m_pen;
  assign if2.PADDR   = m_addr;
  assign if2.PWRITE  = m_wr;
  assign if2.PWDATA  = m_wdata;

  apb_timer_completer #(.BASE_ADDR(32'h0000_1000), .WAIT_STATES(0)) dut0 (
    .PCLK(clk), .PRESET(rst), .bus(if0.slave), .irq(irq0)
  );
  apb_timer_completer #(.BASE_ADDR(32'h0000_1000), .WAIT_STATES(2)) dut2 (
    .PCLK(clk), .PRESET(rst), .bus(if2.slave), .irq(irq2)
  );

  wire        s_pready = m_sel ? if2.PREADY  : if0.PREADY;
  wire [31:0] s_prdata = m_sel ? if2.PRDATA  : if0.PRDATA;
  wire        s_perr   = m_sel ? if2.PSLVERR : if0.PSLVERR;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One APB transfer; starts and ends just after a falling edge so calls chain back-to-back.
  task automatic apb(input bit sel, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rdata, output logic err, output int waits);
    int guard;
    m_sel = sel; m_psel = 1'b1; m_pen = 1'b0; m_addr = addr; m_wr = wr; m_wdata = wdata;
    @(negedge clk);
    m_pen = 1'b1;
    waits = 0;
    guard = 0;
    while (s_pready !== 1'b1 && guard < 40) begin
      waits++;
      guard++;
      @(negedge clk);
    end
    if (guard >= 40) begin
      n_checks++;
      n_fail++;
      $display("FAIL pready_timeout: got no PREADY after %0d cycles expected completion", guard);
    end
    rdata = s_prdata;
    err   = s_perr;
    @(negedge clk);
    m_psel = 1'b0; m_pen = 1'b0; m_wr = 1'b0;
  endtask

  task automatic wr(input bit sel, input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] d; logic e; int w;
    apb(sel, 1'b1, addr, data, d, e, w);
  endtask

  task automatic rd(input bit sel, input logic [31:0] addr, output logic [31:0] data);
    logic e; int w;
    apb(sel, 1'b0, addr, 32'd0, data, e, w);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    bit          err;
  } vec_t;

  vec_t tbl[13];

  initial begin
    logic [31:0] d;
    logic        e;
    int          w;
    int          L, P, a, ie, N, ticks, ec;
    logic [31:0] cfg;
    bit          ee;

    tbl[0]  = '{1'b1, A_LOAD,   32'hF0FF00F0, 32'h00000000, 1'b0};
    tbl[1]  = '{1'b0, A_LOAD,   32'h0,        32'hF0FF00F0, 1'b0};
    tbl[2]  = '{1'b0, A_COUNT,  32'h0,        32'hF0FF00F0, 1'b0};
    tbl[3]  = '{1'b1, A_CTRL,   32'hFFFFFFFE, 32'hF0FF00F0, 1'b0};
    tbl[4]  = '{1'b0, A_CTRL,   32'h0,        32'h0000FF06, 1'b0};
    tbl[5]  = '{1'b1, A_COUNT,  32'h12345678, 32'h0000FF06, 1'b1};
    tbl[6]  = '{1'b0, A_COUNT,  32'h0,        32'hF0FF00F0, 1'b0};
    tbl[7]  = '{1'b0, 32'h1010, 32'h0,        32'h00000000, 1'b1};
    tbl[8]  = '{1'b1, 32'h2004, 32'h00000123, 32'h00000000, 1'b1};
    tbl[9]  = '{1'b0, A_LOAD,   32'h0,        32'hF0FF00F0, 1'b0};
    tbl[10] = '{1'b0, A_STATUS, 32'h0,        32'h00000000, 1'b0};
    tbl[11] = '{1'b1, A_CTRL,   32'h0,        32'h00000000, 1'b0};
    tbl[12] = '{1'b0, A_CTRL,   32'h0,        32'h00000000, 1'b0};

    // Reset held two cycles
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_pready0", {31'd0, if0.PREADY}, 32'd0);
    check("rst_prdata0", if0.PRDATA, 32'd0);
    check("rst_irq0", {31'd0, irq0}, 32'd0);
    check("rst_pready2", {31'd0, if2.PREADY}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    rd(0, A_CTRL, d);   check("rst_ctrl", d, 32'd0);
    rd(0, A_LOAD, d);   check("rst_load", d, 32'd0);
    rd(0, A_COUNT, d);  check("rst_count", d, 32'd0);
    rd(0, A_STATUS, d); check("rst_status", d, 32'd0);

    // Register-access table on the zero-wait-state completer
    for (int i = 0; i < 13; i++) begin
      apb(0, tbl[i].wr, tbl[i].addr, tbl[i].wdata, d, e, w);
      check($sformatf("tbl%0d_rdata", i), d, tbl[i].exp);
      check($sformatf("tbl%0d_err", i), {31'd0, e}, {31'd0, tbl[i].err & ERR_EN});
      check($sformatf("tbl%0d_waits", i), 32'(w), 32'd0);
    end

    // Two wait states: read timing, write, aborted write
    apb(1, 1'b0, A_CTRL, 32'd0, d, e, w);
    check("ws2_read_waits", 32'(w), 32'd2);
    check("ws2_read_data", d, 32'd0);
    apb(1, 1'b1, A_LOAD, 32'h0000A5A5, d, e, w);
    check("ws2_write_waits", 32'(w), 32'd2);
    m_sel = 1'b1; m_psel = 1'b1; m_pen = 1'b0; m_addr = A_LOAD; m_wr = 1'b1; m_wdata = 32'h00001234;
    @(negedge clk);
    m_pen = 1'b1;
    check("abort_pready_c1", {31'd0, if2.PREADY}, 32'd0);
    @(negedge clk);
    check("abort_pready_c2", {31'd0, if2.PREADY}, 32'd0);
    m_psel = 1'b0; m_pen = 1'b0; m_wr = 1'b0;
    @(negedge clk);
    check("abort_pready_c3", {31'd0, if2.PREADY}, 32'd0);
    rd(1, A_LOAD, d);
    check("abort_load_kept", d, 32'h0000A5A5);

    // LOAD=3, P=0 countdown, expire, W1C, then auto-reload
    wr(0, A_CTRL, 32'd0);
    wr(0, A_STATUS, 32'd1);
    wr(0, A_LOAD, 32'd3);
    wr(0, A_CTRL, 32'h5);
    rd(0, A_COUNT, d);  check("cd_count_e1", d, 32'd3);
    rd(0, A_COUNT, d);  check("cd_count_e3", d, 32'd1);
    rd(0, A_STATUS, d); check("cd_expired_e5", d, 32'd1);
    check("cd_irq", {31'd0, irq0}, 32'd1);
    wr(0, A_CTRL, 32'h4);
    wr(0, A_STATUS, 32'd1);
    check("w1c_irq_low", {31'd0, irq0}, 32'd0);
    wr(0, A_CTRL, 32'h7);
    @(negedge clk);
    rd(0, A_COUNT, d);  check("reload_count", d, 32'd3);
    rd(0, A_STATUS, d); check("reload_expired", d, 32'd1);

    // LOAD write lands on a tick cycle: the written value wins
    wr(0, A_LOAD, 32'd9);
    rd(0, A_COUNT, d);  check("load_beats_tick", d, 32'd9);

    // P=3, LOAD=1: expire on the 8th enabled cycle, W1C on that same cycle loses
    wr(0, A_CTRL, 32'd0);
    wr(0, A_STATUS, 32'd1);
    wr(0, A_LOAD, 32'd1);
    wr(0, A_CTRL, 32'h0000_0305);
    repeat (6) @(negedge clk);
    check("p3_irq_before", {31'd0, irq0}, 32'd0);
    wr(0, A_STATUS, 32'd1);
    check("p3_irq_set_wins", {31'd0, irq0}, 32'd1);
    rd(0, A_STATUS, d); check("p3_status_set_wins", d, 32'd1);

    // Randomized runs against a closed-form model of ticks elapsed
    for (int t = 0; t < 16; t++) begin
      L  = int'($urandom_range(0, 12));
      P  = int'($urandom_range(0, 4));
      a  = int'($urandom_range(0, 1));
      ie = int'($urandom_range(0, 1));
      N  = int'($urandom_range(0, 50));
      cfg = {16'd0, P[7:0], 5'd0, ie[0], a[0], 1'b0};
      wr(0, A_CTRL, cfg);
      wr(0, A_STATUS, 32'd1);
      wr(0, A_LOAD, 32'(L));
      wr(0, A_CTRL, cfg | 32'd1);
      repeat (N) @(negedge clk);
      wr(0, A_CTRL, cfg);
      // enabled for the N idle cycles plus the setup and completing cycle of the disabling write
      ticks = (N + 2) / (P + 1);
      if (a != 0)
        ec = L - (ticks % (L + 1));
      else
        ec = (ticks >= L) ? 0 : L - ticks;
      ee = (ticks > L);
      rd(0, A_COUNT, d);
      check($sformatf("rnd%0d_count", t), d, 32'(ec));
      rd(0, A_STATUS, d);
      check($sformatf("rnd%0d_status", t), d, {31'd0, ee});
      check($sformatf("rnd%0d_irq", t), {31'd0, irq0}, {31'd0, ee & ie[0]});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1);
  end

endmodule
